phase_osc: RTL

//  Phase-accumulator oscillator directly downstream of the glide stage. Consumes the

---
 rtl/phase_osc.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/phase_osc.sv
// Phase-accumulator voice oscillator: gated IDLE/RUN/RELEASE phase FSM feeding a
// two-stage waveform pipeline (saw, square, triangle, LFSR noise), one sample per tick.
module phase_osc #(
    parameter int unsigned PHASE_W    = 24,
    parameter int unsigned FREQ_SHIFT = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Enable,
    input  logic        key_on,
    input  logic        sample_tick,
    input  logic [15:0] freq,
    input  logic [1:0]  wave_sel,
    input  logic [15:0] pulse_width,
    output logic [15:0] sample,
    output logic        sample_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [PHASE_W-1:0]   inc;
    logic [PHASE_W:0]     sum;
    logic                 carry;
    logic                 lfsr_fb;

    logic                 s1_valid_q;
    logic [15:0]          s1_p_q;
    logic [15:0]          s1_noise_q;
    logic [1:0]           s1_wave_q;
    logic [15:0]          s1_pw_q;
    logic                 s1_idle_q;

    logic [15:0]          wave_d;
    logic [15:0]          tri_t;
    logic [15:0]          sample_q;
    logic                 sample_valid_q;

    assign inc     = PHASE_W'({freq, {FREQ_SHIFT{1'b0}}});
    assign sum     = {1'b0, phase_q} + {1'b0, inc};
    assign carry   = sum[PHASE_W];
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

    // Enable is applied last so it overrides every state transition.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                if (Enable && key_on) state_d = RUN;
            end
            RUN: begin
                if (sample_tick) phase_d = sum[PHASE_W-1:0];
                if (!key_on) state_d = RELEASE;
            end
            RELEASE: begin
                if ((sample_tick && carry) || (freq == '0)) begin
                    state_d = IDLE;
                    phase_d = '0;
                end else begin
                    if (sample_tick) phase_d = sum[PHASE_W-1:0];
                    if (key_on) state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
        if (!Enable) begin
            state_d = IDLE;
            phase_d = '0;
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (sample_tick && Enable) lfsr_d = {lfsr_fb, lfsr_q[15:1]};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            phase_q <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Stage 1 captures post-tick values, so a wrapping tick is seen as IDLE and outputs 0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s1_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s1_noise_q <= '0;
            s1_wave_q  <= '0;
            s1_pw_q    <= '0;
            s1_idle_q  <= 1'b0;
        end else begin
            s1_valid_q <= sample_tick && Enable;
            if (sample_tick) begin
                s1_p_q     <= phase_d[PHASE_W-1 -: 16];
                s1_noise_q <= lfsr_d;
                s1_wave_q  <= wave_sel;
                s1_pw_q    <= pulse_width;
                s1_idle_q  <= (state_d == IDLE);
            end
        end
    end

    assign tri_t = s1_p_q[15] ? ~{s1_p_q[14:0], 1'b0} : {s1_p_q[14:0], 1'b0};

    always_comb begin
        wave_d = '0;
        case (s1_wave_q)
            2'd0: wave_d = {~s1_p_q[15], s1_p_q[14:0]};
            2'd1: wave_d = (s1_p_q < s1_pw_q) ? 16'h7FFF : 16'h8001;
            2'd2: wave_d = {~tri_t[15], tri_t[14:0]};
            default: wave_d = s1_noise_q;
        endcase
        if (s1_idle_q) wave_d = '0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= s1_valid_q;
            if (s1_valid_q) sample_q <= wave_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;

endmodule
